// File: rtl/pic_pkg.sv
// Shared CSR definitions for the pic_core CSR arbiter: bus widths and op encoding.
package pic_pkg;

    localparam int unsigned PIC_CSR_ADD_WIDTH  = 8;
    localparam int unsigned PIC_CSR_DATA_WIDTH = 32;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/pic_rr_arbiter.sv
// Round-robin arbiter: request vector + pointer -> one-hot grant; the pointer
// moves past the granted requester whenever a grant is issued.
module pic_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic          found;

    // First pass covers [ptr, NUM_REQ-1], second pass wraps to [0, ptr-1].
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (!found && req[j] && (j >= int'(ptr))) begin
                grant[j] = 1'b1;
                found    = 1'b1;
                ptr_nxt  = (j == int'(NUM_REQ) - 1) ? '0 : PW'(j + 1);
            end
        end
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (!found && req[j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
                ptr_nxt  = (j == int'(NUM_REQ) - 1) ? '0 : PW'(j + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/pic_csr_arbiter.sv
// Round-robin sharing of the pic_core CSR port between NUM_REQ requesters.
// Optional grant locking for atomic sequences is enabled by PIC_CSR_ARB_LOCK_EN.
module pic_csr_arbiter
    import pic_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADD_WIDTH  = PIC_CSR_ADD_WIDTH,
    parameter int unsigned DATA_WIDTH = PIC_CSR_DATA_WIDTH
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADD_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [ADD_WIDTH-1:0]          csr_addr,
    output logic                          csr_rd,
    output logic                          csr_wr,
    output logic [DATA_WIDTH-1:0]         csr_wr_data,
    input  logic [DATA_WIDTH-1:0]         csr_rd_data
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      gidx;
    logic               hs;
    logic [NUM_REQ-1:0] tag1;
    logic               rd2;

`ifdef PIC_CSR_ARB_LOCK_EN
    localparam logic [0:0] UNLOCKED = 1'b0;
    localparam logic [0:0] LOCKED   = 1'b1;

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [IW-1:0] owner;
    logic [IW-1:0] owner_nxt;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= UNLOCKED;
            owner <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    // While locked only the owner may compete for the port.
    always_comb begin
        arb_req = req_valid;
        if (state == LOCKED) begin
            arb_req = req_valid & (NUM_REQ'(1) << owner);
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        if (hs) begin
            case (state)
                UNLOCKED: begin
                    if (req_lock[gidx]) begin
                        state_nxt = LOCKED;
                        owner_nxt = gidx;
                    end
                end
                LOCKED: begin
                    if (!req_lock[gidx]) begin
                        state_nxt = UNLOCKED;
                    end
                end
                default: state_nxt = UNLOCKED;
            endcase
        end
    end
`else
    logic unused_lock;

    assign arb_req     = req_valid;
    assign unused_lock = ^req_lock;
`endif

    pic_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk   (aclk),
        .rst_n (aresetn),
        .req   (arb_req),
        .grant (grant)
    );

    assign req_ready = grant & {NUM_REQ{aresetn}};
    assign hs        = |req_ready;

    always_comb begin
        gidx = '0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (grant[j]) begin
                gidx = IW'(j);
            end
        end
    end

    // Issue stage: the CSR port is driven from registers, one access per handshake.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            csr_rd      <= 1'b0;
            csr_wr      <= 1'b0;
            csr_addr    <= '0;
            csr_wr_data <= '0;
            tag1        <= '0;
        end else begin
            csr_rd <= hs && (req_wr[gidx] == OP_RD);
            csr_wr <= hs && (req_wr[gidx] == OP_WR);
            tag1   <= req_ready;
            if (hs) begin
                csr_addr    <= req_addr[32'(gidx)*ADD_WIDTH +: ADD_WIDTH];
                csr_wr_data <= req_wdata[32'(gidx)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Response stage: owner tag routes the completion pulse.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rsp_valid <= '0;
            rd2       <= 1'b0;
        end else begin
            rsp_valid <= tag1;
            rd2       <= csr_rd;
        end
    end

    // Core read data arrives in the response cycle, so it is forwarded, not re-registered.
    assign rsp_rdata = rd2 ? csr_rd_data : '0;

endmodule

// File: tb/tb_pic_csr_arbiter.sv
// Scoreboard bench for pic_csr_arbiter with a bram-style pic_core model.
module tb_pic_csr_arbiter;
    import pic_pkg::*;

    localparam int N = 2;

    typedef struct packed {
        logic        wr;
        logic        lock;
        logic [7:0]  addr;
        logic [31:0] data;
    } op_t;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        int unsigned cyc;
    } csr_exp_t;

    typedef struct packed {
        logic [0:0]  id;
        logic [31:0] rdata;
        int unsigned cyc;
    } rsp_exp_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_wr;
    logic [N-1:0]  req_lock;
    logic [N*8-1:0]  req_addr;
    logic [N*32-1:0] req_wdata;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  rsp_valid;
    logic [31:0]   rsp_rdata;
    logic [7:0]    csr_addr;
    logic          csr_rd;
    logic          csr_wr;
    logic [31:0]   csr_wr_data;
    logic [31:0]   csr_rd_data;

    pic_csr_arbiter #(.NUM_REQ(N), .ADD_WIDTH(8), .DATA_WIDTH(32)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .req_valid   (req_valid),
        .req_wr      (req_wr),
        .req_lock    (req_lock),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .csr_addr    (csr_addr),
        .csr_rd      (csr_rd),
        .csr_wr      (csr_wr),
        .csr_wr_data (csr_wr_data),
        .csr_rd_data (csr_rd_data)
    );

    always #5 aclk = ~aclk;

    int unsigned cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // pic_core model: read data valid the cycle after csr_rd.
    logic [31:0] core_mem [256];
    always @(posedge aclk) begin
        if (csr_rd) csr_rd_data <= core_mem[csr_addr];
        if (csr_wr) core_mem[csr_addr] <= csr_wr_data;
    end

    logic [31:0] ref_mem [256];
    op_t         q0[$];
    op_t         q1[$];
    csr_exp_t    csr_q[$];
    rsp_exp_t    rsp_q[$];
    int          gnt_id[$];
    int unsigned gnt_cyc[$];
    int          errors = 0;
    int          checks = 0;
    bit          no_rsp = 1'b0;
    logic [N-1:0] hs;
    op_t         cur_op;
    csr_exp_t    ce;
    rsp_exp_t    re;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver: records handshakes into the scoreboard, then presents the next queued op.
    initial begin : driver
        req_valid = '0; req_wr = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        forever begin
            @(negedge aclk);
            hs = req_valid & req_ready;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    cur_op = (i == 0) ? q0[0] : q1[0];
                    csr_q.push_back('{wr: cur_op.wr, addr: cur_op.addr, data: cur_op.data, cyc: cyc + 1});
                    if (!no_rsp)
                        rsp_q.push_back('{id: 1'(i), rdata: cur_op.wr ? 32'h0 : ref_mem[cur_op.addr], cyc: cyc + 2});
                    if (cur_op.wr) ref_mem[cur_op.addr] = cur_op.data;
                    gnt_id.push_back(i);
                    gnt_cyc.push_back(cyc);
                end
            end
            @(posedge aclk);
            #1;
            if (hs[0]) q0.delete(0);
            if (hs[1]) q1.delete(0);
            req_valid[0] = (q0.size() > 0);
            if (q0.size() > 0) begin
                req_wr[0] = q0[0].wr; req_lock[0] = q0[0].lock;
                req_addr[7:0] = q0[0].addr; req_wdata[31:0] = q0[0].data;
            end
            req_valid[1] = (q1.size() > 0);
            if (q1.size() > 0) begin
                req_wr[1] = q1[0].wr; req_lock[1] = q1[0].lock;
                req_addr[15:8] = q1[0].addr; req_wdata[63:32] = q1[0].data;
            end
        end
    end

    // Monitor: pops and compares whenever the DUT presents a CSR access or a response.
    initial begin : monitor
        forever begin
            @(negedge aclk);
            if (csr_rd || csr_wr) begin
                check("csr_rd_wr_excl", 64'(csr_rd & csr_wr), 64'h0);
                if (csr_q.size() == 0) begin
                    check("csr_unexpected", 64'(csr_addr), 64'hFFFF);
                end else begin
                    ce = csr_q.pop_front();
                    check("csr_op", 64'(csr_wr), 64'(ce.wr));
                    check("csr_addr", 64'(csr_addr), 64'(ce.addr));
                    if (ce.wr) check("csr_wr_data", 64'(csr_wr_data), 64'(ce.data));
                    check("csr_cycle", 64'(cyc), 64'(ce.cyc));
                end
            end
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'h0);
                end else begin
                    re = rsp_q.pop_front();
                    check("rsp_valid", 64'(rsp_valid), 64'(2'b01 << re.id));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(re.rdata));
                    check("rsp_cycle", 64'(cyc), 64'(re.cyc));
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while ((q0.size() + q1.size() + csr_q.size() + rsp_q.size()) != 0 && n < 60) begin
            @(negedge aclk);
            n++;
        end
        check({name, "_drain"}, 64'(q0.size() + q1.size() + csr_q.size() + rsp_q.size()), 64'h0);
        @(negedge aclk);
        #2;
    endtask

    task automatic check_grant(input string name, input int k, input int id, input int dcyc, input int base);
        if (gnt_id.size() <= base + k) begin
            check({name, "_missing"}, 64'(gnt_id.size()), 64'(base + k + 1));
        end else begin
            check({name, "_id"}, 64'(gnt_id[base + k]), 64'(id));
            check({name, "_cyc"}, 64'(gnt_cyc[base + k] - gnt_cyc[base]), 64'(dcyc));
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int base;
        int n;
        for (int a = 0; a < 256; a++) begin
            core_mem[a] = 32'h0;
            ref_mem[a]  = 32'h0;
        end
        core_mem[8'h04] = 32'hDEADBEEF;
        core_mem[8'h0C] = 32'h12345678;
        ref_mem[8'h04]  = 32'hDEADBEEF;
        ref_mem[8'h0C]  = 32'h12345678;

        // Reset state, with a request pending that must not be granted.
        aresetn = 1'b0;
        q0.push_back('{wr: OP_RD, lock: 1'b0, addr: 8'h04, data: 32'h0});
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_csr_rd", 64'(csr_rd), 64'h0);
        check("rst_csr_wr", 64'(csr_wr), 64'h0);
        check("rst_csr_addr", 64'(csr_addr), 64'h0);
        check("rst_csr_wr_data", 64'(csr_wr_data), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
        check("rst_req_ready", 64'(req_ready), 64'h0);

        // Test 1: single read of 0x04.
        base = gnt_id.size();
        @(posedge aclk); #1; aresetn = 1'b1;
        wait_idle("t1");
        check_grant("t1_g0", 0, 0, 0, base);

        // Test 3: req1 alone right after a req0 grant.
        base = gnt_id.size();
        q0.push_back('{wr: OP_WR, lock: 1'b0, addr: 8'h10, data: 32'hA5A50010});
        @(negedge aclk); #2;
        q1.push_back('{wr: OP_RD, lock: 1'b0, addr: 8'h10, data: 32'h0});
        wait_idle("t3");
        check_grant("t3_g0", 0, 0, 0, base);
        check_grant("t3_g1", 1, 1, 1, base);

        // Test 2: both requesters writing 0x08 every cycle.
        base = gnt_id.size();
        for (int k = 0; k < 4; k++) begin
            q0.push_back('{wr: OP_WR, lock: 1'b0, addr: 8'h08, data: 32'h0});
            q1.push_back('{wr: OP_WR, lock: 1'b0, addr: 8'h08, data: 32'h1});
        end
        wait_idle("t2");
        for (int k = 0; k < 8; k++) check_grant("t2_g", k, k % 2, k, base);

        // Test 4: reset the cycle after a read handshake.
        no_rsp = 1'b1;
        base = gnt_id.size();
        q0.push_back('{wr: OP_RD, lock: 1'b0, addr: 8'h04, data: 32'h0});
        n = 0;
        while (gnt_id.size() == base && n < 20) begin
            @(negedge aclk); #2;
            n++;
        end
        check("t4_hs_seen", 64'(gnt_id.size()), 64'(base + 1));
        @(posedge aclk); #1;
        aresetn = 1'b0;
        no_rsp = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        check("t4_csr_rd", 64'(csr_rd), 64'h0);
        check("t4_rsp_valid", 64'(rsp_valid), 64'h0);
        base = gnt_id.size();
        q1.push_back('{wr: OP_RD, lock: 1'b0, addr: 8'h08, data: 32'h0});
        q0.push_back('{wr: OP_RD, lock: 1'b0, addr: 8'h0C, data: 32'h0});
        repeat (2) @(negedge aclk);
        check("t4_rst_ready", 64'(req_ready), 64'h0);
        @(posedge aclk); #1; aresetn = 1'b1;
        wait_idle("t4");
        check_grant("t4_ptr0", 0, 0, 0, base);
        check_grant("t4_g1", 1, 1, 1, base);

        // Tests 5/6: read-modify-write on 0x0C with req1 competing.
        base = gnt_id.size();
        q0.push_back('{wr: OP_RD, lock: 1'b1, addr: 8'h0C, data: 32'h0});
        q0.push_back('{wr: OP_WR, lock: 1'b0, addr: 8'h0C, data: 32'h12345679});
        q1.push_back('{wr: OP_WR, lock: 1'b0, addr: 8'h20, data: 32'h00000055});
        wait_idle("t5");
        check_grant("t5_g0", 0, 0, 0, base);
`ifdef PIC_CSR_ARB_LOCK_EN
        check_grant("t5_g1", 1, 0, 1, base);
        check_grant("t5_g2", 2, 1, 2, base);
`else
        check_grant("t6_g1", 1, 1, 1, base);
        check_grant("t6_g2", 2, 0, 2, base);
`endif
        repeat (3) @(negedge aclk);
        check("end_csr_q", 64'(csr_q.size()), 64'h0);
        check("end_rsp_q", 64'(rsp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
